// File: rtl/main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_responder
// Purpose  : Main-memory side of the cache<->memory link. Serves line-fill
//            reads as an in-order burst of WORDS_PER_LINE beats and commits
//            write-through words. Every access waits a fixed LATENCY before
//            any data moves or any commit happens. A single transaction is
//            outstanding at a time, and requests seen while busy are dropped.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous, active-high
//            mem_req    - request valid (taken when mem_req & mem_ready)
//            mem_rw     - 1 = word write, 0 = line read
//            mem_addr   - word address (read: any word in the line)
//            mem_wdata  - write data
//            mem_ready  - idle / able to accept
//            mem_rvalid - read beat valid
//            mem_rdata  - read beat data
//            mem_beat   - beat index within the line
//            mem_done   - one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module main_memory_responder #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int LATENCY        = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_req,
    input  logic                              mem_rw,
    input  logic [ADDR_W-1:0]                 mem_addr,
    input  logic [DATA_W-1:0]                 mem_wdata,
    output logic                              mem_ready,
    output logic                              mem_rvalid,
    output logic [DATA_W-1:0]                 mem_rdata,
    output logic [$clog2(WORDS_PER_LINE)-1:0] mem_beat,
    output logic                              mem_done
);

    localparam int C_BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int C_LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int C_DEPTH  = 1 << ADDR_W;

    localparam logic [C_LAT_W-1:0]  C_LAT_LAST  = C_LAT_W'(LATENCY - 1);
    localparam logic [C_BEAT_W-1:0] C_BEAT_LAST = C_BEAT_W'(WORDS_PER_LINE - 1);

    localparam logic [1:0] C_IDLE  = 2'd0;
    localparam logic [1:0] C_WAIT  = 2'd1;
    localparam logic [1:0] C_BURST = 2'd2;
    localparam logic [1:0] C_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [C_LAT_W-1:0]  r_lat_cnt;
    logic                r_rw;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_mem [0:C_DEPTH-1];

    logic                w_accept;
    logic                w_lat_last;
    logic                w_beat_last;
    logic                w_commit;
    logic                w_ready_d;
    logic                w_rvalid_d;
    logic                w_done_d;
    logic [C_BEAT_W-1:0] w_beat_d;
    logic [ADDR_W-1:0]   w_rd_addr;

    assign w_accept    = (r_state == C_IDLE) && mem_req;
    assign w_lat_last  = (r_lat_cnt == C_LAT_LAST);
    assign w_beat_last = (mem_beat == C_BEAT_LAST);
    // The write lands on the final WAIT edge so it is visible before done.
    assign w_commit    = (r_state == C_WAIT) && w_lat_last && r_rw;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE:  if (mem_req)     w_next_state = C_WAIT;
            C_WAIT:  if (w_lat_last)  w_next_state = r_rw ? C_DONE : C_BURST;
            C_BURST: if (w_beat_last) w_next_state = C_DONE;
            C_DONE:                   w_next_state = C_IDLE;
            default:                  w_next_state = C_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: values the output registers take at the next edge,
    // derived from the state being entered so the ports stay registered.
    // ------------------------------------------------------------------
    always_comb begin
        w_ready_d  = (w_next_state == C_IDLE);
        w_rvalid_d = (w_next_state == C_BURST);
        w_done_d   = (w_next_state == C_DONE);
        // A fresh burst always starts at beat 0 (no critical-word-first).
        w_beat_d   = (r_state == C_BURST) ? (mem_beat + C_BEAT_W'(1)) : '0;
        // Line base with the beat index spliced into the low bits.
        w_rd_addr  = {r_addr[ADDR_W-1:C_BEAT_W], w_beat_d};
    end

    // ------------------------------------------------------------------
    // Output registers, latency counter and request capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_ready  <= 1'b1;
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
            mem_beat   <= '0;
            mem_done   <= 1'b0;
            r_lat_cnt  <= '0;
            r_rw       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else begin
            mem_ready  <= w_ready_d;
            mem_rvalid <= w_rvalid_d;
            mem_done   <= w_done_d;
            // Beat and data hold their last value outside a burst.
            if (w_rvalid_d) begin
                mem_beat  <= w_beat_d;
                mem_rdata <= r_mem[w_rd_addr];
            end
            if (r_state == C_WAIT) begin
                r_lat_cnt <= r_lat_cnt + C_LAT_W'(1);
            end else begin
                r_lat_cnt <= '0;
            end
            if (w_accept) begin
                r_rw    <= mem_rw;
                r_addr  <= mem_addr;
                r_wdata <= mem_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Backing array: contents are not reset. A reset on the commit edge
    // drops the pending write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && w_commit) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_main_memory_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_memory_responder
// Purpose  : Self-checking bench for main_memory_responder. Holds a word-level
//            reference memory and checks the cycle timing of every transaction
//            in terms of its offset from the accept edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_memory_responder;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int WPL    = 4;
    localparam int LAT    = 3;

    logic              clk;
    logic              reset;
    logic              mem_req;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        mem_beat;
    logic              mem_done;

    int errors = 0;
    int checks = 0;

    // Reference memory: value plus a flag saying whether it was ever written.
    logic [DATA_W-1:0] model_mem   [256];
    bit                model_known [256];

    main_memory_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(WPL), .LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_beat(mem_beat),
        .mem_done(mem_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at a negedge with ready high or times out.
    task automatic wait_ready(input string name);
        int n = 0;
        while (mem_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout: ready=%b required=1", name, mem_ready);
        end
    endtask

    // Presents a request at a negedge; accept happens on the following posedge.
    // Inputs are scrambled after accept. Returns at the negedge of accept+1.
    task automatic issue(input bit rw, input logic [7:0] a, input logic [31:0] d);
        mem_req   = 1'b1;
        mem_rw    = rw;
        mem_addr  = a;
        mem_wdata = d;
        @(posedge clk);
        #1;
        mem_req   = 1'b0;
        mem_rw    = 1'($urandom);
        mem_addr  = 8'($urandom);
        mem_wdata = $urandom;
        @(negedge clk);
    endtask

    task automatic do_write(input string name, input logic [7:0] a, input logic [31:0] d);
        bit [2:0] exp_flags;
        wait_ready(name);
        issue(1'b1, a, d);
        for (int k = 1; k <= LAT + 2; k++) begin
            if (k > 1) @(negedge clk);
            exp_flags = {(k == LAT + 2), 1'b0, (k == LAT + 1)};
            checks++;
            if ({mem_ready, mem_rvalid, mem_done} !== exp_flags) begin
                errors++;
                $display("FAIL %s write_timing k=%0d rdy/rv/done=%b required=%b",
                         name, k, {mem_ready, mem_rvalid, mem_done}, exp_flags);
            end
        end
        model_mem[a]   = d;
        model_known[a] = 1'b1;
    endtask

    // With disturb set, a write request to 0x20 is held on the bus for every
    // busy cycle and dropped before the responder returns to ready.
    task automatic do_read(input string name, input logic [7:0] a, input bit disturb);
        bit [2:0]   exp_flags;
        int         base;
        logic [7:0] wa;
        int         b;
        wait_ready(name);
        issue(1'b0, a, 32'h0);
        base = (int'(a) / WPL) * WPL;
        for (int k = 1; k <= LAT + WPL + 2; k++) begin
            if (k > 1) @(negedge clk);
            exp_flags = {(k == LAT + WPL + 2), (k > LAT && k <= LAT + WPL), (k == LAT + WPL + 1)};
            checks++;
            if ({mem_ready, mem_rvalid, mem_done} !== exp_flags) begin
                errors++;
                $display("FAIL %s read_timing k=%0d rdy/rv/done=%b required=%b",
                         name, k, {mem_ready, mem_rvalid, mem_done}, exp_flags);
            end
            if (exp_flags[1]) begin
                b  = k - LAT - 1;
                wa = 8'((base + b) % 256);
                checks++;
                if (mem_beat !== 2'(b)) begin
                    errors++;
                    $display("FAIL %s beat_index k=%0d got=%0d required=%0d", name, k, mem_beat, b);
                end
                if (model_known[wa]) begin
                    checks++;
                    if (mem_rdata !== model_mem[wa]) begin
                        errors++;
                        $display("FAIL %s beat_data addr=%h got=%h required=%h",
                                 name, wa, mem_rdata, model_mem[wa]);
                    end
                end
            end
            if (disturb) begin
                mem_req   = (k <= LAT + WPL);
                mem_rw    = 1'b1;
                mem_addr  = 8'h20;
                mem_wdata = 32'hBAD0_BAD0;
            end
        end
        mem_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_ready, mem_rvalid, mem_done, mem_beat, mem_rdata} !== {3'b100, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL reset_values rdy/rv/done=%b beat=%0d rdata=%h required=100/0/0",
                     {mem_ready, mem_rvalid, mem_done}, mem_beat, mem_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_ready, mem_rvalid, mem_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_idle rdy/rv/done=%b required=100", {mem_ready, mem_rvalid, mem_done});
        end
    endtask

    task automatic test_write_latency();
        do_write("write_latency", 8'h13, 32'hDEAD_BEEF);
    endtask

    task automatic test_line_read();
        for (int i = 0; i < 4; i++) do_write("line_preload", 8'(8'h10 + i), 32'(32'hA0 + i));
        do_read("line_read", 8'h12, 1'b0);
    endtask

    task automatic test_top_line();
        for (int i = 0; i < 4; i++) do_write("top_preload", 8'(8'hFC + i), 32'(32'hF00 + i));
        do_write("top_preload", 8'h00, 32'h1234_5678);
        do_read("top_line", 8'hFE, 1'b0);
    endtask

    task automatic test_busy_ignore();
        do_write("busy_preload", 8'h20, 32'h2020_2020);
        do_read("busy_read", 8'h10, 1'b1);
        do_read("busy_unchanged", 8'h20, 1'b0);
        do_write("busy_reissue", 8'h20, 32'hBAD0_BAD0);
        do_read("busy_reissue_rd", 8'h20, 1'b0);
    endtask

    task automatic test_reset_abort();
        do_write("abort_preload", 8'h30, 32'h3030_3030);
        wait_ready("abort");
        issue(1'b1, 8'h30, 32'hFFFF_0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({mem_ready, mem_rvalid, mem_done, mem_beat, mem_rdata} !== {3'b100, 2'b00, 32'h0}) begin
            errors++;
            $display("FAIL abort_reset_values rdy/rv/done=%b beat=%0d rdata=%h required=100/0/0",
                     {mem_ready, mem_rvalid, mem_done}, mem_beat, mem_rdata);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_ready, mem_done} !== 2'b10) begin
                errors++;
                $display("FAIL abort_no_done cyc=%0d rdy/done=%b required=10", k, {mem_ready, mem_done});
            end
        end
        do_read("abort_old_value", 8'h30, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_write("b2b_write", 8'h08, 32'h0000_0055);
        checks++;
        if (mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready ready=%b required=1", mem_ready);
        end
        do_read("b2b_read", 8'h08, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write("rand_write", a, $urandom);
            else                           do_read("rand_read", a, 1'b0);
        end
    endtask

    initial begin
        reset     = 1'b1;
        mem_req   = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            model_mem[i]   = '0;
            model_known[i] = 1'b0;
        end
        @(negedge clk);
        test_reset();
        test_write_latency();
        test_line_read();
        test_top_line();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
